ysyx_23060208_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060208_mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the single instruction/data memory port between the IFU (master 0) and the LSU (master 1).
- Accepts valid/ready requests from both masters and grants one at a time.
- Registers the granted request and forwards it to the slave.
- Routes the slave response back to the owning master.
- Exactly one transaction is outstanding at any time.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; write mask width is DATA_WIDTH/8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
m0_req_valid  in  1  IFU request valid
m0_req_ready  out  1  IFU request accepted (grant)
m0_addr  in  ADDR_WIDTH  IFU address
m0_rsp_valid  out  1  IFU response valid
m0_rsp_ready  in  1  IFU response accept
m1_req_valid  in  1  LSU request valid
m1_req_ready  out  1  LSU request accepted (grant)
m1_addr  in  ADDR_WIDTH  LSU address
m1_wen  in  1  LSU write enable
m1_wdata  in  DATA_WIDTH  LSU write data
m1_wmask  in  DATA_WIDTH/8  LSU byte mask
m1_rsp_valid  out  1  LSU response valid
m1_rsp_ready  in  1  LSU response accept
m_rdata  out  DATA_WIDTH  read data, shared by both masters
m_rsp_err  out  1  error flag, shared, qualified by mX_rsp_valid
s_req_valid  out  1  slave request valid
s_req_ready  in  1  slave request accept
s_addr  out  ADDR_WIDTH  registered address
s_wen  out  1  registered write enable
s_wdata  out  DATA_WIDTH  registered write data
s_wmask  out  DATA_WIDTH/8  registered byte mask
s_rsp_valid  in  1  slave response valid
s_rsp_ready  out  1  slave response accept
s_rdata  in  DATA_WIDTH  slave read data
s_rsp_err  in  1  slave error

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, owner=0, rr_last=1 (IFU favoured first under RR), s_addr/s_wen/s_wdata/s_wmask=0.
  - All valid and ready outputs are 0 while in reset and on exit from reset.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any mX_req_valid: arbitrate and assert the winner's mX_req_ready combinationally in the same cycle.
  - Capture the winner's request into the s_* registers. For m0, s_wen=0, s_wdata=0, s_wmask=0.
  - Set owner and go to REQ. The loser's req_ready stays 0.
  - If no mX_req_valid, stay in IDLE.
- REQ:
  - s_req_valid=1 with the registered fields held stable.
  - On s_req_ready, go to RESP; otherwise stay.
  - All mX_req_ready=0.
- RESP:
  - s_rsp_ready = owner's mX_rsp_ready. Owner's mX_rsp_valid = s_rsp_valid. The non-owner's rsp_valid=0.
  - m_rdata=s_rdata and m_rsp_err=s_rsp_err pass through combinationally.
  - On s_rsp_valid && owner rsp_ready, go to IDLE.
- Latency:
  - Grant at cycle T, s_req_valid at T+1.
  - With zero-wait slave acceptance and a response the following cycle, the master sees rsp_valid at T+2.
  - Back-to-back: the next grant can occur in the cycle after the response handshake.
- Simultaneous m0/m1 request in IDLE: resolved per the arbitration policy (see Optional Feature).
- Request arriving in REQ/RESP: held off (req_ready=0); the master keeps valid asserted until granted.
- Response stall: the owner holding rsp_ready=0 keeps the FSM in RESP and back-pressures the slave; no data is lost.
- Reset mid-transaction: returns to IDLE immediately. The in-flight transaction is dropped and s_req_valid/s_rsp_ready deassert asynchronously.
- Writes also complete through RESP: the slave returns a response, and its rdata is ignored by the LSU.

Optional Feature:
YSYX_23060208_ARB_RR_EN
- Defined: round-robin arbitration. rr_last records the last granted master, updated on each grant; on simultaneous requests the master not equal to rr_last wins.
- Undefined: fixed priority, LSU (m1) over IFU (m0); rr_last is absent.

Test Plan:
- Single IFU read:
  - Stimulus: m0_req_valid=1, m0_addr=0x80000000; slave accepts immediately, returns s_rdata=0x00000413 one cycle later.
  - Response: m0_req_ready at T, s_req_valid/s_addr=0x80000000 at T+1, m0_rsp_valid with m_rdata=0x00000413 at T+2; m1_rsp_valid stays 0.
- LSU write:
  - Stimulus: m1 wen=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF.
  - Response: slave sees exactly those values with s_wen=1; m1_rsp_valid pulses once; FSM returns to IDLE.
- Simultaneous requests, 4 back-to-back each:
  - Without the macro: all 4 LSU grants precede any IFU grant.
  - With YSYX_23060208_ARB_RR_EN: grants alternate m0,m1,m0,m1,…
- Stalls:
  - Stimulus: s_req_ready low for 3 cycles, then m0_rsp_ready low for 2 cycles after s_rsp_valid.
  - Response: s_* fields stable throughout, s_rsp_ready follows m0_rsp_ready, exactly one response delivered, no new grant meanwhile.
- Error response:
  - Stimulus: s_rsp_err=1 on an LSU read.
  - Response: m1_rsp_valid=1 with m_rsp_err=1.
- Reset in RESP:
  - Stimulus: drive rst=0 for one cycle while in RESP.
  - Response: all valid/ready outputs 0 immediately, state=IDLE; after rst returns to 1, a fresh m0 request is granted normally.

Source files
------------

// File: rtl/ysyx_23060208_mem_arbiter.sv
// Two-master (IFU=m0, LSU=m1) to one-slave memory arbiter with one outstanding transaction.
// Define YSYX_23060208_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
`timescale 1ns/1ps
module ysyx_23060208_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  output logic                    m0_rsp_valid,
  input  logic                    m0_rsp_ready,
  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic                    m1_wen,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask,
  output logic                    m1_rsp_valid,
  input  logic                    m1_rsp_ready,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    m_rsp_err,
  output logic                    s_req_valid,
  input  logic                    s_req_ready,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic                    s_wen,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wmask,
  input  logic                    s_rsp_valid,
  output logic                    s_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_rsp_err
);

  localparam int MaskWidth = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MaskWidth-1:0]    wmask_q, wmask_d;
  logic                    grant0, grant1;
  logic                    ownerRspReady;

`ifdef YSYX_23060208_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  // On a tie the master that did not win last time goes first.
  assign grant1 = m1_req_valid && (!m0_req_valid || !rr_last_q);
`else
  assign grant1 = m1_req_valid;
`endif
  assign grant0 = m0_req_valid && !grant1;

  assign ownerRspReady = owner_q ? m1_rsp_ready : m0_rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef YSYX_23060208_ARB_RR_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
`ifdef YSYX_23060208_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
`ifdef YSYX_23060208_ARB_RR_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d = REQ;
          owner_d = grant1;
          addr_d  = grant1 ? m1_addr : m0_addr;
          wen_d   = grant1 && m1_wen;
          wdata_d = grant1 ? m1_wdata : '0;
          wmask_d = grant1 ? m1_wmask : '0;
`ifdef YSYX_23060208_ARB_RR_EN
          rr_last_d = grant1;
`endif
        end
      end
      REQ: begin
        if (s_req_ready) state_d = RESP;
      end
      RESP: begin
        if (s_rsp_valid && ownerRspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    s_req_valid  = 1'b0;
    s_rsp_ready  = 1'b0;
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          m0_req_ready = grant0;
          m1_req_ready = grant1;
        end
        REQ: s_req_valid = 1'b1;
        RESP: begin
          s_rsp_ready  = ownerRspReady;
          m0_rsp_valid = !owner_q && s_rsp_valid;
          m1_rsp_valid = owner_q && s_rsp_valid;
        end
        default: ;
      endcase
    end
  end

  assign s_addr    = addr_q;
  assign s_wen     = wen_q;
  assign s_wdata   = wdata_q;
  assign s_wmask   = wmask_q;
  assign m_rdata   = s_rdata;
  assign m_rsp_err = s_rsp_err;

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Randomized self-checking bench for ysyx_23060208_mem_arbiter against a transaction-level model.
// Honours YSYX_23060208_ARB_RR_EN in its arbitration model.
`timescale 1ns/1ps
module tb_ysyx_23060208_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
  logic [31:0] m0_addr;
  logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_wen;
  logic [3:0]  m1_wmask;
  logic [31:0] m_rdata;
  logic        m_rsp_err;
  logic        s_req_valid, s_req_ready, s_wen, s_rsp_valid, s_rsp_ready, s_rsp_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;

  ysyx_23060208_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m_rdata(m_rdata), .m_rsp_err(m_rsp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rdata(s_rdata), .s_rsp_err(s_rsp_err)
  );

  always #5 clk = ~clk;

  // Model state: pending request per master plus the last granted master.
  logic [1:0]  pend;
  logic [31:0] addrQ [2];
  logic        wenM1;
  logic [31:0] wdataM1;
  logic [3:0]  wmaskM1;
  logic        rrLast;
  int          grantLog[$];
  int          checks = 0;
  int          fails = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic modelWinner();
`ifdef YSYX_23060208_ARB_RR_EN
    if (pend == 2'b11) return !rrLast;
`endif
    return pend[1];
  endfunction

  task automatic setM0(input logic [31:0] a);
    pend[0]  = 1'b1;
    addrQ[0] = a;
  endtask

  task automatic setM1(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    pend[1]  = 1'b1;
    addrQ[1] = a;
    wenM1    = w;
    wdataM1  = d;
    wmaskM1  = m;
  endtask

  // One full transaction from IDLE; optionally resets the DUT in the first RESP cycle.
  task automatic applyStimulus(input int reqStall, input int rspDelay, input int ownStall,
                               input logic [31:0] rdata, input logic err, input logic abortInResp);
    logic        w, ownReady, ownValid;
    logic [31:0] eAddr, eWdata;
    logic        eWen;
    logic [3:0]  eWmask;
    int          delivered;
    m0_req_valid = pend[0];
    m0_addr      = addrQ[0];
    m1_req_valid = pend[1];
    m1_addr      = addrQ[1];
    m1_wen       = wenM1;
    m1_wdata     = wdataM1;
    m1_wmask     = wmaskM1;
    w      = modelWinner();
    eAddr  = addrQ[w];
    eWen   = w ? wenM1 : 1'b0;
    eWdata = w ? wdataM1 : 32'h0;
    eWmask = w ? wmaskM1 : 4'h0;
    @(negedge clk);
    checkOutput("m0_req_ready grant", m0_req_ready, !w);
    checkOutput("m1_req_ready grant", m1_req_ready, w);
    checkOutput("s_req_valid idle", s_req_valid, 1'b0);
    @(posedge clk); #1;
    pend[w] = 1'b0;
    rrLast  = w;
    grantLog.push_back(int'(w));
    if (w) m1_req_valid = 1'b0;
    else   m0_req_valid = 1'b0;
    for (int i = 0; i <= reqStall; i++) begin
      s_req_ready = (i == reqStall);
      @(negedge clk);
      checkOutput("s_req_valid", s_req_valid, 1'b1);
      checkOutput("s_addr", s_addr, eAddr);
      checkOutput("s_wen", s_wen, eWen);
      checkOutput("s_wdata", s_wdata, eWdata);
      checkOutput("s_wmask", s_wmask, eWmask);
      checkOutput("req_ready in REQ", {m0_req_ready, m1_req_ready}, 2'b00);
      @(posedge clk); #1;
    end
    s_req_ready = 1'b0;
    delivered = 0;
    for (int j = 0; j <= rspDelay + ownStall; j++) begin
      s_rsp_valid = (j >= rspDelay);
      s_rdata     = s_rsp_valid ? rdata : $urandom;
      s_rsp_err   = s_rsp_valid ? err : 1'($urandom_range(0, 1));
      ownReady    = (j == rspDelay + ownStall);
      if (w) begin
        m1_rsp_ready = ownReady;
        m0_rsp_ready = 1'($urandom_range(0, 1));
      end else begin
        m0_rsp_ready = ownReady;
        m1_rsp_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      checkOutput("s_req_valid in RESP", s_req_valid, 1'b0);
      checkOutput("req_ready in RESP", {m0_req_ready, m1_req_ready}, 2'b00);
      checkOutput("s_rsp_ready", s_rsp_ready, ownReady);
      checkOutput("m0_rsp_valid", m0_rsp_valid, !w && s_rsp_valid);
      checkOutput("m1_rsp_valid", m1_rsp_valid, w && s_rsp_valid);
      if (s_rsp_valid) begin
        checkOutput("m_rdata", m_rdata, rdata);
        checkOutput("m_rsp_err", m_rsp_err, err);
      end
      if (abortInResp) begin
        m0_req_valid = 1'b1;
        m1_req_valid = 1'b1;
        s_rsp_valid  = 1'b1;
        s_req_ready  = 1'b1;
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        checkOutput("handshakes in reset",
                    {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready}, 6'h0);
        checkOutput("s_addr in reset", s_addr, 32'h0);
        @(posedge clk); #1;
        checkOutput("handshakes held in reset",
                    {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready}, 6'h0);
        @(negedge clk);
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        s_rsp_valid  = 1'b0;
        s_req_ready  = 1'b0;
        m0_rsp_ready = 1'b0;
        m1_rsp_ready = 1'b0;
        pend   = 2'b00;
        rrLast = 1'b1;
        rst    = 1'b1;
        @(posedge clk); #1;
        return;
      end
      ownValid = w ? m1_rsp_valid : m0_rsp_valid;
      if (ownValid && ownReady) delivered++;
      @(posedge clk); #1;
    end
    s_rsp_valid  = 1'b0;
    m0_rsp_ready = 1'b0;
    m1_rsp_ready = 1'b0;
    checkOutput("responses delivered", delivered, 1);
  endtask

  initial begin
    int c0, c1;
    rst = 1'b0;
    pend = 2'b00;
    rrLast = 1'b1;
    addrQ[0] = 32'h0;
    addrQ[1] = 32'h0;
    wenM1 = 1'b0; wdataM1 = 32'h0; wmaskM1 = 4'h0;
    m0_req_valid = 1'b1; m0_addr = 32'h0; m0_rsp_ready = 1'b0;
    m1_req_valid = 1'b0; m1_addr = 32'h0; m1_wen = 1'b0; m1_wdata = 32'h0; m1_wmask = 4'h0;
    m1_rsp_ready = 1'b0;
    s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rdata = 32'h0; s_rsp_err = 1'b0;
    #12;
    checkOutput("reset handshakes",
                {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, s_req_valid, s_rsp_ready}, 6'h0);
    checkOutput("reset s_addr", s_addr, 32'h0);
    checkOutput("reset s_wdata", s_wdata, 32'h0);
    checkOutput("reset s_wmask/wen", {s_wmask, s_wen}, 5'h0);
    m0_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    setM0(32'h8000_0000);
    applyStimulus(0, 0, 0, 32'h0000_0413, 1'b0, 1'b0);
    setM1(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(0, 1, 0, $urandom, 1'b0, 1'b0);

    grantLog.delete();
    c0 = 4;
    c1 = 4;
    for (int k = 0; k < 8; k++) begin
      if (!pend[0] && c0 > 0) begin setM0($urandom & 32'hFFFF_FFFC); c0--; end
      if (!pend[1] && c1 > 0) begin
        setM1($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
        c1--;
      end
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom, 1'b0, 1'b0);
    end
`ifdef YSYX_23060208_ARB_RR_EN
    for (int k = 1; k < 8; k++) checkOutput("burst alternation", grantLog[k] != grantLog[k-1], 1'b1);
`else
    for (int k = 0; k < 4; k++) checkOutput("burst LSU first", grantLog[k], 1);
`endif

    setM0(32'h8000_0040);
    applyStimulus(3, 0, 2, 32'h1234_5678, 1'b0, 1'b0);
    setM1(32'h8000_2000, 1'b0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 32'hBAD0_BAD0, 1'b1, 1'b0);
    setM0(32'h8000_0080);
    applyStimulus(0, 0, 1, 32'h5555_AAAA, 1'b0, 1'b1);
    setM0(32'h8000_00C0);
    applyStimulus(0, 0, 0, 32'h0000_0013, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if (!pend[0] && $urandom_range(0, 1) == 1) setM0($urandom);
      if (!pend[1] && $urandom_range(0, 1) == 1)
        setM1($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      if (pend == 2'b00) begin
        if ($urandom_range(0, 1) == 1) setM0($urandom);
        else setM1($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      end
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
